// File: rtl/btn_intr_ctrl.sv
// Button interrupt controller: counts debounced presses per source and presents
// them one at a time to the core as a level request plus source ID.
//
// state | meaning
// IDLE  | pick lowest pending+enabled source, raise INTR
// REQ   | INTR held with INTR_ID until the core acknowledges
// GAP   | one forced INTR-low cycle before the next decision
module btn_intr_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 4,
  parameter int ID_W    = 2
) (
  input  logic               CLK_50,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] EVT,
  input  logic [NUM_SRC-1:0] EN_MASK,
  input  logic               INTR_ACK,
  input  logic               CLR_OVF,
  output logic               INTR,
  output logic [ID_W-1:0]    INTR_ID,
  output logic [NUM_SRC-1:0] PEND,
  output logic [NUM_SRC-1:0] OVF
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                          state_q, state_d;
  logic                            intr_q, intr_d;
  logic [ID_W-1:0]                 id_q, id_d;
  logic [NUM_SRC-1:0]              evt_q;
  logic [NUM_SRC-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0]              ovf_q, ovf_d;

  logic [NUM_SRC-1:0] press;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ret_vec;
  logic [ID_W-1:0]    pick_id;
  logic               retire;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) PEND[i] = (cnt_q[i] != '0);
  end

  assign press    = EVT & ~evt_q;
  assign eligible = PEND & EN_MASK;

  // Descending scan so the lowest eligible index is the last one written.
  always_comb begin
    pick_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) pick_id = ID_W'(i);
    end
  end

  always_ff @(posedge CLK_50) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (eligible != '0) state_d = REQ;
      REQ:     if (INTR_ACK)       state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    intr_d  = (state_d == REQ);
    id_d    = id_q;
    retire  = (state_q == REQ) && INTR_ACK;
    ret_vec = '0;
    if (state_q == IDLE && eligible != '0) id_d = pick_id;
    if (retire) ret_vec = NUM_SRC'(1) << id_q;
  end

  // A press and a retire on the same source cancel; overflow only on a pure press.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      ovf_d[i] = ovf_q[i] & ~CLR_OVF;
      if (press[i] && !ret_vec[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (ret_vec[i] && !press[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_50) begin
    if (RST) begin
      intr_q <= 1'b0;
      id_q   <= '0;
      evt_q  <= '1;
      cnt_q  <= '0;
      ovf_q  <= '0;
    end else begin
      intr_q <= intr_d;
      id_q   <= id_d;
      evt_q  <= EVT;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign INTR    = intr_q;
  assign INTR_ID = id_q;
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_btn_intr_ctrl.sv
// Directed bench for btn_intr_ctrl (NUM_SRC=4, CNT_W=2): expected request IDs are
// queued as presses are driven and popped as the DUT raises INTR.
module tb_btn_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] evt, en_mask, pend, ovf;
  logic       ack, clr_ovf, intr;
  logic [1:0] intr_id;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int mcnt[4];
  logic [3:0] movf;
  int last_id;

  btn_intr_ctrl #(.NUM_SRC(4), .CNT_W(2), .ID_W(2)) dut (
    .CLK_50(clk), .RST(rst), .EVT(evt), .EN_MASK(en_mask), .INTR_ACK(ack),
    .CLR_OVF(clr_ovf), .INTR(intr), .INTR_ID(intr_id), .PEND(pend), .OVF(ovf)
  );

  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_pend();
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = (mcnt[i] != 0);
    return p;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    movf = '0;
    exp_q.delete();
  endtask

  task automatic press(input int src);
    evt[src] = 1'b1;
    if (mcnt[src] == 3) movf[src] = 1'b1;
    else begin
      mcnt[src]++;
      exp_q.push_back(src);
    end
    tick();
    evt[src] = 1'b0;
    tick();
  endtask

  task automatic take(input string tag);
    int n = 0;
    while (intr !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, intr, 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected"}, exp_q.size(), 1);
      last_id = 0;
    end else begin
      last_id = exp_q.pop_front();
      chk({tag, "_id"}, intr_id, last_id);
    end
  endtask

  task automatic ack_it(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    if (mcnt[last_id] > 0) mcnt[last_id]--;
    chk({tag, "_ack_intr"}, intr, 0);
    chk({tag, "_ack_pend"}, pend, model_pend());
  endtask

  task automatic serve(input string tag);
    take(tag);
    ack_it(tag);
  endtask

  task automatic quiet(input string tag, input int n);
    logic hi = 1'b0;
    repeat (n) begin
      tick();
      if (intr !== 1'b0) hi = 1'b1;
    end
    chk({tag, "_quiet"}, hi, 0);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; evt = '0; en_mask = 4'hF; ack = 1'b0; clr_ovf = 1'b0;
    model_clear();
    tick(); tick();
    chk("rst_intr", intr, 0);
    chk("rst_id", intr_id, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    // single press held 4 cycles counts once
    evt[2] = 1'b1; mcnt[2]++; exp_q.push_back(2);
    tick();
    chk("single_pend", pend, 4'b0100);
    chk("single_intr_early", intr, 0);
    tick();
    chk("single_intr", intr, 1);
    chk("single_id", intr_id, 2);
    tick(); tick();
    evt[2] = 1'b0;
    tick();
    chk("single_once", pend, 4'b0100);
    serve("single");
    quiet("single", 6);

    // simultaneous presses: lowest index first, 2-cycle gap
    evt = 4'b1010; mcnt[1]++; mcnt[3]++; exp_q.push_back(1); exp_q.push_back(3);
    tick();
    evt = '0;
    chk("prio_pend", pend, 4'b1010);
    tick();
    take("prio1");
    ack_it("prio1");
    tick();
    chk("prio_gap", intr, 0);
    tick();
    chk("prio_reassert", intr, 1);
    take("prio2");
    ack_it("prio2");
    quiet("prio", 10);

    // masked presses queue up, request held when mask drops in REQ
    en_mask = '0;
    press(0); press(0); press(0);
    tick(); tick();
    chk("mask_pend", pend, 4'b0001);
    chk("mask_intr", intr, 0);
    en_mask = 4'b0001;
    tick();
    chk("mask_raise", intr, 1);
    en_mask = '0;
    tick(); tick();
    chk("mask_hold", intr, 1);
    serve("mask1");
    en_mask = 4'b0001;
    serve("mask2");
    serve("mask3");
    quiet("mask", 8);
    chk("mask_pend_done", pend, 0);

    // saturation at 3 with sticky overflow
    en_mask = '0;
    repeat (5) press(1);
    chk("sat_ovf", ovf, movf);
    chk("sat_ovf_bit", ovf, 4'b0010);
    chk("sat_pend", pend, 4'b0010);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("sat_clr", ovf, 0);
    evt[1] = 1'b1; clr_ovf = 1'b1;
    tick();
    evt[1] = 1'b0; clr_ovf = 1'b0;
    tick();
    chk("sat_set_wins", ovf, 4'b0010);
    en_mask = 4'hF;
    serve("sat1"); serve("sat2"); serve("sat3");
    quiet("sat", 8);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("sat_clr2", ovf, 0);

    // press and ack of the same source in one cycle
    press(0);
    take("same1");
    evt[0] = 1'b1; ack = 1'b1; exp_q.push_back(0);
    tick();
    evt[0] = 1'b0; ack = 1'b0;
    chk("same_intr", intr, 0);
    chk("same_pend", pend, 4'b0001);
    chk("same_ovf", ovf, 0);
    tick();
    chk("same_gap", intr, 0);
    tick();
    chk("same_reassert", intr, 1);
    take("same2");
    ack_it("same2");
    quiet("same", 6);

    // reset mid-request clears counts and overflow
    en_mask = '0;
    repeat (4) press(3);
    press(2);
    en_mask = 4'hF;
    tick();
    chk("rreq_intr", intr, 1);
    chk("rreq_ovf", ovf, 4'b1000);
    rst = 1'b1;
    tick();
    model_clear();
    chk("rreq_intr_clr", intr, 0);
    chk("rreq_pend_clr", pend, 0);
    chk("rreq_ovf_clr", ovf, 0);
    evt[1] = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("rrel_pend", pend, 0);
    chk("rrel_intr", intr, 0);
    evt[1] = 1'b0;
    tick();

    // stray ack in IDLE does nothing
    en_mask = '0;
    press(0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    chk("spur_pend", pend, 4'b0001);
    chk("spur_intr", intr, 0);
    en_mask = 4'hF;
    serve("spur");
    quiet("spur", 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_intr_ctrl.md
# btn_intr_ctrl

Interrupt request controller placed directly downstream of the button debouncers. It takes the one-shot outputs of up to `NUM_SRC` debouncers and counts each button press per source, saturating at the counter's maximum. It presents one press at a time to the OTTER core as a level interrupt request plus a source ID, and retires that press when the core acknowledges it. Presses that arrive while a request is outstanding are queued rather than lost.

## Interface
- `NUM_SRC`, default 4: number of button event sources, range 1..16.
- `CNT_W`, default 4: width of each per-source press counter; saturates at 2^CNT_W-1.
- `ID_W`, default 2: width of `INTR_ID`; must be ≥ max(1, clog2(NUM_SRC)).

Ports:
- `CLK_50`  in  1  50 MHz system clock; all state updates on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `EVT`  in  NUM_SRC  debouncer one-shot pulses, synchronous to CLK_50. A pulse may stay high for several cycles.
- `EN_MASK`  in  NUM_SRC  per-source interrupt enable; 1 = eligible to raise INTR.
- `INTR_ACK`  in  1  single-cycle acknowledge from the core.
- `INTR`  out  1  registered interrupt request level.
- `INTR_ID`  out  ID_W  registered index of the source being requested; valid while INTR=1.
- `PEND`  out  NUM_SRC  PEND[i]=1 when cnt[i]≠0, regardless of mask.
- `OVF`  out  NUM_SRC  sticky: a press on source i was dropped because cnt[i] was saturated.
- `CLR_OVF`  in  1  single-cycle pulse; clears all OVF bits.

## Operation
- **Edge detect.** Each source keeps a registered copy `evt_q[i]`. A press is `EVT[i] & ~evt_q[i]`.
  - A multi-cycle one-shot therefore counts exactly once.
  - `evt_q` resets to all ones, so a level already high when reset is released is not counted.
- **Counters.** `cnt[i]` is CNT_W bits, reset 0.
  - Press alone: +1, or hold at max and set OVF[i].
  - Retire alone: -1.
  - Press and retire of the same source in the same cycle: net unchanged, OVF not set.
  - A counter never underflows, because a retire only happens for a source with cnt≠0.
- **OVF.** Set has priority over CLR_OVF in the same cycle for the affected bit. All other bits clear.
- **FSM states:** IDLE, REQ, GAP. Reset state is IDLE.
  - **IDLE:** eligible = PEND & EN_MASK. If eligible≠0, latch the lowest eligible index into INTR_ID, set INTR=1, go to REQ. Otherwise stay in IDLE.
  - **REQ:** INTR held at 1, INTR_ID held.
    - Mask changes are ignored; a request is never retracted.
    - On INTR_ACK: retire one press of source INTR_ID, INTR←0, go to GAP.
  - **GAP:** INTR=0 for one cycle, then go to IDLE unconditionally. This guarantees the core sees an INTR low gap between back-to-back requests.
- **INTR_ACK outside REQ** is ignored and has no effect.
- **Priority.** Fixed: lowest index wins. A higher-index source is served only when no lower-index eligible source is pending.
- **Reset values:** INTR=0, INTR_ID=0, PEND=0, OVF=0, all cnt=0, state IDLE, evt_q=all ones.
- **Reset mid-request** clears everything. Queued presses are discarded and no retire occurs.

## Timing
- All outputs except PEND come straight from registers. PEND is a decode of cnt registers only and has no input-to-output combinational path.
- Press latency, for EVT[i] rising and first sampled at edge t, from IDLE:
  - cnt[i] increments at edge t, so PEND[i]=1 after t.
  - INTR=1 with INTR_ID=i after edge t+1.
- Acknowledge, for INTR_ACK sampled high at edge a in REQ:
  - INTR=0 and cnt decremented after edge a.
  - GAP during cycle a..a+1.
  - Earliest re-assertion of INTR is after edge a+2.
- Minimum INTR low time between requests is 2 cycles (GAP, then the IDLE decision cycle).
- Throughput: one retired press per 3 cycles at best (REQ with same-cycle ACK, GAP, IDLE).
- A 4-cycle debouncer one-shot on CLK_50 is fully handled by this block. Presses on different sources in the same cycle are all counted.

## Test plan
- **Single press, NUM_SRC=4:** EVT[2] high for 4 cycles with EN_MASK=4'b1111.
  - Required: PEND=4'b0100 one cycle later, then INTR=1, INTR_ID=2.
  - ACK → INTR=0 next cycle, PEND=0. The press counts once, not 4 times.
- **Priority and queuing:** EVT[3] and EVT[1] rise in the same cycle.
  - Required: first request ID=1; after ACK, 2 cycles of INTR low, then ID=3.
  - No third request follows.
- **Masking:** EN_MASK=0, press source 0 three times.
  - Required: PEND[0]=1, INTR stays 0.
  - Set EN_MASK[0]=1 → exactly 3 requests of ID 0, each retired by an ACK.
  - Clear the mask while in REQ → INTR holds until ACK.
- **Saturation, CNT_W=2:** 5 presses on source 1 with the mask off.
  - Required: cnt=3 and OVF[1]=1.
  - Enable the mask → exactly 3 requests.
  - CLR_OVF → OVF=0. CLR_OVF in the same cycle as another overflowing press → OVF[1] stays 1.
- **Simultaneous press and ack on the same source:** cnt[0]=1, INTR_ID=0, EVT[0] edge in the same cycle as INTR_ACK.
  - Required: cnt[0] stays 1 and a second request follows after GAP.
- **Reset and spurious ack:**
  - RST asserted in REQ → next cycle INTR=0, PEND=0, OVF=0.
  - EVT held high across reset release → no count.
  - INTR_ACK pulsed in IDLE → no state or count change.
